// File: rtl/bcd_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_mux
// Brief    : 4-digit multiplexed 7-segment driver with frame-coherent digit
//            snapshots and a one-cycle ghost guard. Optional new-record blink
//            is compiled in with the BLINK_NEW_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [3:0] cnt0,
  input  logic [3:0] cnt1,
  input  logic [3:0] cnt2,
  input  logic [3:0] cnt3,
  input  logic [3:0] rec0,
  input  logic [3:0] rec1,
  input  logic [3:0] rec2,
  input  logic [3:0] rec3,
  input  logic       show_rec,
  input  logic       new_rec,   // "new" is a reserved word in SystemVerilog
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int                    c_presc_w    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_presc_w-1:0]  c_presc_last = c_presc_w'(REFRESH_DIV - 1);
  localparam logic [3:0]            c_an_off     = 4'b1111;
  localparam logic [3:0]            c_an_dp      = 4'b0111;
  localparam logic [6:0]            c_seg_off    = 7'b1111111;
  localparam logic [6:0]            c_seg_dash   = 7'b0111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = c_seg_dash;
    endcase
    return pattern;
  endfunction

  logic [c_presc_w-1:0] presc_q, presc_d;
  logic [1:0]           idx_q, idx_d;
  logic                 started_q, started_d;
  logic [15:0]          snap_q, snap_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  logic                 tick;
  logic                 frame_start;
  logic [15:0]          live_digits;
  logic [3:0]           next_digit;
  logic                 blank;

  always_comb begin
    tick        = (presc_q == c_presc_last);
    // The first tick after reset opens a frame on digit 0 instead of advancing.
    frame_start = tick && (!started_q || (idx_q == 2'd3));
    live_digits = show_rec ? {rec3, rec2, rec1, rec0} : {cnt3, cnt2, cnt1, cnt0};

    presc_d    = tick ? '0 : presc_q + 1'b1;
    started_d  = started_q | tick;
    idx_d      = (tick && started_q) ? idx_q + 2'd1 : idx_q;
    snap_d     = frame_start ? live_digits : snap_q;
    next_digit = snap_d[{idx_d, 2'b00} +: 4];

    seg_d = tick ? seg_decode(next_digit) : seg_q;
    if (tick || !started_q || blank) begin
      an_d = c_an_off;
    end else begin
      an_d = ~(4'b0001 << idx_q);
    end
    dp_d = (an_d != c_an_dp);
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
      snap_q    <= '0;
      an_q      <= c_an_off;
      seg_q     <= c_seg_off;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

`ifdef BLINK_NEW_EN
  localparam int                   c_frame_w    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(BLINK_FRAMES - 1);

  logic [c_frame_w-1:0] frame_q, frame_d;
  logic                 phase_q, phase_d;
  logic                 snap_rec_q, snap_rec_d;
  logic                 snap_new_q, snap_new_d;

  always_comb begin
    frame_d    = frame_q;
    phase_d    = phase_q;
    snap_rec_d = snap_rec_q;
    snap_new_d = snap_new_q;
    if (frame_start) begin
      snap_rec_d = show_rec;
      snap_new_d = new_rec;
      if (!new_rec) begin
        frame_d = '0;
        phase_d = 1'b0;
      end else if (snap_new_q) begin
        // Counting starts after the onset frame, so the first BLINK_FRAMES frames stay lit.
        if (frame_q == c_frame_last) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      frame_q    <= '0;
      phase_q    <= 1'b0;
      snap_rec_q <= 1'b0;
      snap_new_q <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      snap_rec_q <= snap_rec_d;
      snap_new_q <= snap_new_d;
    end
  end

  assign blank = phase_q & snap_new_q & ~snap_rec_q;
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic          unused_new_rec;

  assign unused_new_rec = new_rec;
  assign blank          = 1'b0;
`endif

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire
